// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter.
//   arb_state_t     : arbiter state encoding (IDLE, GNT0, GNT1)
//   DEFAULT_TIMEOUT : default number of unacknowledged strobe cycles allowed
//                     before the granted master is given an error
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Two-master, one-slave Wishbone B4 arbiter. Master 0 is the instruction
// fetch port, master 1 the data port. Grants alternate when both request,
// an owner keeps the bus for as long as it holds cyc, and a watchdog
// counter turns a strobe that is never acknowledged into a one-cycle error.
//
// Ports
//   clk, rst           : clock, asynchronous active-low reset
//   m0_* / m1_*        : master request (cyc, stb, we, adr, dat_o, sel) in,
//                        master response (ack, err, dat_i) out
//   s_*                : shared slave request out (cyc, stb, we, adr, dat_o,
//                        sel), slave response in (ack, dat_i)
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_o,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  output logic                m0_err,
  output logic [DATA_W-1:0]   m0_dat_i,

  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_o,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [DATA_W-1:0]   m1_dat_i,

  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_o,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_dat_i
);

  // A TIMEOUT of 0 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  arb_state_t       r_state;
  logic             r_last_owner;
  logic [CNT_W-1:0] r_tmo_cnt;

  logic w_timeout;
  logic w_owner_id;
  logic w_own_cyc;
  logic w_other_cyc;

  // Read data is broadcast; only the ack/err qualifiers are steered.
  assign m0_dat_i = s_dat_i;
  assign m1_dat_i = s_dat_i;

  assign w_timeout   = (r_state != IDLE) && (r_tmo_cnt == CNT_LIMIT);
  assign w_owner_id  = (r_state == GNT1);
  assign w_own_cyc   = w_owner_id ? m1_cyc : m0_cyc;
  assign w_other_cyc = w_owner_id ? m0_cyc : m1_cyc;

  // Slave-side mux and response steering. In the timeout cycle the slave
  // request is withdrawn; an ack arriving in that same cycle still wins,
  // which is why err is qualified by ~s_ack rather than the other way round.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    case (r_state)
      GNT0: begin
        s_cyc   = m0_cyc & ~w_timeout;
        s_stb   = m0_stb & ~w_timeout;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_o = m0_dat_o;
        s_sel   = m0_sel;
        m0_ack  = s_ack;
        m0_err  = w_timeout & ~s_ack;
      end
      GNT1: begin
        s_cyc   = m1_cyc & ~w_timeout;
        s_stb   = m1_stb & ~w_timeout;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_o = m1_dat_o;
        s_sel   = m1_sel;
        m1_ack  = s_ack;
        m1_err  = w_timeout & ~s_ack;
      end
      default: begin
      end
    endcase
  end

  // Arbitration FSM with the watchdog counter. last_owner resets to 1 so
  // that the first contested grant after reset goes to master 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_tmo_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tmo_cnt <= '0;
          if (m0_cyc && (!m1_cyc || r_last_owner)) begin
            r_state <= GNT0;
          end else if (m1_cyc) begin
            r_state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (w_timeout && !s_ack) begin
            r_state      <= IDLE;
            r_last_owner <= w_owner_id;
            r_tmo_cnt    <= '0;
          end else if (w_own_cyc) begin
            if (s_ack) begin
              r_tmo_cnt <= '0;
            end else if (s_stb && (r_tmo_cnt < CNT_LIMIT)) begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end else begin
            // Owner released the bus: hand over directly if the other
            // master is waiting, so no idle cycle is inserted.
            r_last_owner <= w_owner_id;
            r_tmo_cnt    <= '0;
            if (w_other_cyc) begin
              r_state <= w_owner_id ? GNT0 : GNT1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule
